// File: rtl/bus_arb_pkg.sv
// Shared definitions for the bus arbiter controller: FSM state encoding,
// destination-field width and the broadcast destination ID.
package bus_arb_pkg;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        POP  = 2'd1,
        PUSH = 2'd2
    } state_t;

    localparam int          DEST_W   = 8;
    localparam logic [7:0]  BCAST_ID = 8'hFF;

endpackage

// File: rtl/bus_arb_ctrl_rr_arbiter.sv
// Combinational round-robin arbiter. The search starts at last_grant+1 and
// wraps modulo n_req, so the most recently served requester has the lowest
// priority.
module rr_arbiter #(
    parameter int n_req = 4,
    parameter int idx_w = (n_req > 1) ? $clog2(n_req) : 1
) (
    input  logic [n_req-1:0] req,
    input  logic [idx_w-1:0] last_grant,
    output logic [idx_w-1:0] gnt_idx,
    output logic             gnt_valid
);

    logic [idx_w-1:0] cand;

    // Walk the request vector once around the ring; the first hit wins.
    always_comb begin
        gnt_idx   = '0;
        gnt_valid = 1'b0;
        cand      = last_grant;
        for (int k = 0; k < n_req; k++) begin
            cand = (cand == idx_w'(n_req - 1)) ? '0 : cand + idx_w'(1);
            if (req[cand] && !gnt_valid) begin
                gnt_idx   = cand;
                gnt_valid = 1'b1;
            end
        end
    end

endmodule

// File: rtl/bus_arb_ctrl.sv
// Bus arbiter controller: moves one packet at a time from a requesting
// device's FIFO head to the destination device(s).
// Optional feature: define BUS_ARB_BCAST_EN to deliver destination 8'hFF to
// every device except the source; otherwise 8'hFF is dropped like any other
// out-of-range destination.
//
// state | meaning
// ------+-------------------------------------------------------------
// IDLE  | waiting for any pndng; round-robin pick of the next winner
// POP   | pop[winner] high; winner's head packet captured at cycle end
// PUSH  | captured packet on D_push, push[dest] high; last_grant updated
module bus_arb_ctrl #(
    parameter int pckg_sz = 16,
    parameter int drvrs   = 4
) (
    input  logic                       clock,
    input  logic                       reset,
    input  logic [drvrs-1:0]           pndng,
    input  logic [drvrs*pckg_sz-1:0]   D_pop,
    output logic [drvrs-1:0]           pop,
    output logic [drvrs-1:0]           push,
    output logic [drvrs*pckg_sz-1:0]   D_push,
    output logic                       busy,
    output logic [15:0]                drop_cnt
);

    import bus_arb_pkg::*;

    localparam int IW = $clog2(drvrs);

    state_t              state, state_nxt;
    logic [IW-1:0]       winner, winner_nxt;
    logic [IW-1:0]       last_grant, last_grant_nxt;
    logic [IW-1:0]       gnt_idx;
    logic                gnt_valid;
    logic [pckg_sz-1:0]  head_pkt;
    logic [DEST_W-1:0]   dest;
    logic [drvrs-1:0]    pop_nxt;
    logic [drvrs-1:0]    push_nxt;
    logic                pkt_load;
    logic                drop_inc;

    rr_arbiter #(
        .n_req (drvrs),
        .idx_w (IW)
    ) u_rr_arbiter (
        .req        (pndng),
        .last_grant (last_grant),
        .gnt_idx    (gnt_idx),
        .gnt_valid  (gnt_valid)
    );

    // Select the winner's head-of-FIFO packet; only meaningful in POP.
    always_comb begin
        head_pkt = '0;
        for (int k = 0; k < drvrs; k++) begin
            if (winner == IW'(k)) begin
                head_pkt = D_pop[k*pckg_sz +: pckg_sz];
            end
        end
    end

    assign dest = head_pkt[pckg_sz-1 -: DEST_W];

    // Next-state and next-output decode; every output is loaded into a flop.
    always_comb begin
        state_nxt      = state;
        winner_nxt     = winner;
        last_grant_nxt = last_grant;
        pop_nxt        = '0;
        push_nxt       = '0;
        pkt_load       = 1'b0;
        drop_inc       = 1'b0;
        case (state)
            IDLE: begin
                if (gnt_valid) begin
                    state_nxt        = POP;
                    winner_nxt       = gnt_idx;
                    pop_nxt[gnt_idx] = 1'b1;
                end
            end
            POP: begin
                // Winner is frozen here, so later pndng changes cannot
                // disturb the transaction already decided.
                state_nxt = PUSH;
                pkt_load  = 1'b1;
`ifdef BUS_ARB_BCAST_EN
                if (dest == BCAST_ID) begin
                    push_nxt         = '1;
                    push_nxt[winner] = 1'b0;
                end else if (dest < DEST_W'(drvrs)) begin
                    push_nxt[dest[IW-1:0]] = 1'b1;
                end else begin
                    drop_inc = 1'b1;
                end
`else
                if (dest < DEST_W'(drvrs)) begin
                    push_nxt[dest[IW-1:0]] = 1'b1;
                end else begin
                    drop_inc = 1'b1;
                end
`endif
            end
            PUSH: begin
                state_nxt      = IDLE;
                last_grant_nxt = winner;
            end
            default: begin
                state_nxt = IDLE;
            end
        endcase
    end

    // FSM state register.
    always_ff @(posedge clock) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= state_nxt;
        end
    end

    // Registered outputs, winner and round-robin pointer.
    always_ff @(posedge clock) begin
        if (reset) begin
            pop        <= '0;
            push       <= '0;
            busy       <= 1'b0;
            winner     <= '0;
            last_grant <= IW'(drvrs - 1);
        end else begin
            pop        <= pop_nxt;
            push       <= push_nxt;
            busy       <= (state_nxt != IDLE);
            winner     <= winner_nxt;
            last_grant <= last_grant_nxt;
        end
    end

    // Packet register: the same packet is presented to every device.
    always_ff @(posedge clock) begin
        if (reset) begin
            D_push <= '0;
        end else if (pkt_load) begin
            D_push <= {drvrs{head_pkt}};
        end
    end

    // Saturating count of packets with an undeliverable destination.
    always_ff @(posedge clock) begin
        if (reset) begin
            drop_cnt <= '0;
        end else if (drop_inc && (drop_cnt != 16'hFFFF)) begin
            drop_cnt <= drop_cnt + 16'd1;
        end
    end

endmodule

// File: tb/tb_bus_arb_ctrl.sv
// Directed bench for bus_arb_ctrl with drvrs=4, pckg_sz=16.
module tb_bus_arb_ctrl;

    logic        clock;
    logic        reset;
    logic [3:0]  pndng;
    logic [63:0] D_pop;
    logic [3:0]  pop;
    logic [3:0]  push;
    logic [63:0] D_push;
    logic        busy;
    logic [15:0] drop_cnt;

    int vec_cnt = 0;
    int err_cnt = 0;

    // Per-device packets for the round-robin runs (dev3..dev0).
    localparam logic [63:0] RR_PKTS = {16'h0333, 16'h0322, 16'h0211, 16'h0100};

    bus_arb_ctrl #(
        .pckg_sz (16),
        .drvrs   (4)
    ) dut (
        .clock    (clock),
        .reset    (reset),
        .pndng    (pndng),
        .D_pop    (D_pop),
        .pop      (pop),
        .push     (push),
        .D_push   (D_push),
        .busy     (busy),
        .drop_cnt (drop_cnt)
    );

    initial clock = 1'b0;
    always #5 clock = ~clock;

    task automatic chk(input string tag, input logic [63:0] obs, input logic [63:0] exp);
        vec_cnt++;
        if (obs !== exp) begin
            err_cnt++;
            $display("FAIL %s: got %0h expected %0h", tag, obs, exp);
        end
    endtask

    task automatic do_reset();
        reset = 1'b1;
        pndng = '0;
        @(posedge clock); #1;
        @(posedge clock); #1;
        @(negedge clock);
        chk("rst_pop", pop, 4'b0);
        chk("rst_push", push, 4'b0);
        chk("rst_busy", busy, 1'b0);
        chk("rst_drop", drop_cnt, 16'h0);
        chk("rst_dpush", D_push, 64'h0);
        @(posedge clock); #1;
        reset = 1'b0;
    endtask

    // One full transaction starting in IDLE (cycle N); returns at N+3.
    task automatic xfer(input string tag, input logic [3:0] pend, input logic [3:0] pend_after,
                        input logic [63:0] dpop, input logic [3:0] exp_pop,
                        input logic [3:0] exp_push, input logic [15:0] exp_data);
        pndng = pend;
        D_pop = dpop;
        @(negedge clock);
        chk({tag, "_idle_busy"}, busy, 1'b0);
        chk({tag, "_idle_push"}, push, 4'b0);
        @(posedge clock); #1;
        pndng = pend_after;
        @(negedge clock);
        chk({tag, "_pop"}, pop, exp_pop);
        chk({tag, "_pop_push"}, push, 4'b0);
        chk({tag, "_pop_busy"}, busy, 1'b1);
        @(posedge clock); #1;
        @(negedge clock);
        chk({tag, "_push"}, push, exp_push);
        chk({tag, "_push_pop"}, pop, 4'b0);
        chk({tag, "_push_busy"}, busy, 1'b1);
        if (exp_push != 4'b0) chk({tag, "_data"}, D_push[15:0], exp_data);
        @(posedge clock); #1;
    endtask

    initial begin
        reset = 1'b1;
        pndng = '0;
        D_pop = '0;

        // Basic latency: device 0 sends 16'h02AB to device 2.
        do_reset();
        xfer("basic", 4'b0001, 4'b0001, {48'h0, 16'h02AB}, 4'b0001, 4'b0100, 16'h02AB);
        pndng = '0;
        @(negedge clock);
        chk("basic_end_busy", busy, 1'b0);
        chk("basic_end_push", push, 4'b0);

        // All pending: grant order 0,1,2,3,0,1,2,3 (dev3 is loopback).
        do_reset();
        for (int r = 0; r < 2; r++) begin
            xfer("rr0", 4'b1111, 4'b1111, RR_PKTS, 4'b0001, 4'b0010, 16'h0100);
            xfer("rr1", 4'b1111, 4'b1111, RR_PKTS, 4'b0010, 4'b0100, 16'h0211);
            xfer("rr2", 4'b1111, 4'b1111, RR_PKTS, 4'b0100, 4'b1000, 16'h0322);
            xfer("rr3", 4'b1111, 4'b1111, RR_PKTS, 4'b1000, 4'b1000, 16'h0333);
        end

        // pndng changes during POP must not redirect the transaction.
        do_reset();
        xfer("chg", 4'b0100, 4'b1011, {16'h0, 16'h0122, 32'h0}, 4'b0100, 4'b0010, 16'h0122);

        // Out-of-range destination from device 1 is dropped.
        do_reset();
        xfer("drop", 4'b0010, 4'b0010, {32'h0, 16'h07CD, 16'h0}, 4'b0010, 4'b0000, 16'h0);
        pndng = '0;
        @(negedge clock);
        chk("drop_cnt", drop_cnt, 16'd1);

        // Broadcast ID from device 2.
        do_reset();
`ifdef BUS_ARB_BCAST_EN
        xfer("bcast", 4'b0100, 4'b0100, {16'h0, 16'hFF11, 32'h0}, 4'b0100, 4'b1011, 16'hFF11);
        pndng = '0;
        @(negedge clock);
        chk("bcast_drop", drop_cnt, 16'd0);
`else
        xfer("bcast", 4'b0100, 4'b0100, {16'h0, 16'hFF11, 32'h0}, 4'b0100, 4'b0000, 16'h0);
        pndng = '0;
        @(negedge clock);
        chk("bcast_drop", drop_cnt, 16'd1);
`endif

        // Reset during PUSH aborts, clears drop_cnt and restores device-0 priority.
        do_reset();
        xfer("pre", 4'b0010, 4'b0010, {32'h0, 16'h07CD, 16'h0}, 4'b0010, 4'b0000, 16'h0);
        pndng = 4'b0100;
        D_pop = {16'h0, 16'h0055, 32'h0};
        @(posedge clock); #1;
        @(negedge clock);
        chk("abort_pop", pop, 4'b0100);
        @(posedge clock); #1;
        @(negedge clock);
        chk("abort_push", push, 4'b0001);
        chk("abort_drop_pre", drop_cnt, 16'd1);
        reset = 1'b1;
        @(posedge clock); #1;
        reset = 1'b0;
        pndng = '0;
        @(negedge clock);
        chk("abort_push_clr", push, 4'b0);
        chk("abort_busy", busy, 1'b0);
        chk("abort_drop", drop_cnt, 16'd0);
        @(posedge clock); #1;
        xfer("after", 4'b1111, 4'b1111, RR_PKTS, 4'b0001, 4'b0010, 16'h0100);
        pndng = '0;

        $display("== %0d vectors applied, %0d miscompares ==", vec_cnt, err_cnt);
        $finish;
    end

    // Absolute time limit so the run always ends.
    initial begin
        #200000;
        $display("FAIL timeout: got running expected finished");
        $fatal(1);
    end

endmodule

// File: doc/bus_arb_ctrl.md
BUS_ARB_CTRL -- requirements
Module: bus_arb_ctrl

Interface
REQ-001 SHALL have parameter: pckg_sz, 16, packet width in bits; bits [pckg_sz-1:pckg_sz-8] are the destination ID.
REQ-002 SHALL have parameter: drvrs, 4, number of attached devices (2..16).
REQ-003 SHALL have port: clock  input  1  single clock; all logic on rising edge.
REQ-004 SHALL have port: reset  input  1  synchronous, active-high reset.
REQ-005 SHALL have port: pndng  input  drvrs  per-device "FIFO not empty"; D_pop[i] is valid whenever pndng[i]=1 (first-word fall-through).
REQ-006 SHALL have port: D_pop  input  drvrs x pckg_sz  per-device head-of-FIFO packet.
REQ-007 SHALL have port: pop  output  drvrs  one-hot, one-cycle dequeue strobe.
REQ-008 SHALL have port: push  output  drvrs  one-cycle enqueue strobe to destination device(s).
REQ-009 SHALL have port: D_push  output  drvrs x pckg_sz  packet driven to every device; meaningful only where push[i]=1.
REQ-010 SHALL have port: busy  output  1  high in any state other than IDLE.
REQ-011 SHALL have port: drop_cnt  output  16  count of discarded packets, saturating at 16'hFFFF.

Function
REQ-012 SHALL implement FSM IDLE -> POP -> PUSH -> IDLE; all outputs registered.
REQ-013 IDLE: if any pndng=1, SHALL select the winner by round-robin starting at last_grant+1 (mod drvrs) and go to POP; otherwise stay in IDLE.
REQ-014 POP: SHALL assert pop[winner] for exactly one cycle and capture D_pop[winner] into the packet register in that same cycle.
REQ-015 PUSH: SHALL drive the captured packet on D_push and assert push[dest] for exactly one cycle, update last_grant=winner, then return to IDLE.
REQ-016 Latency SHALL be as follows: pndng high in IDLE at cycle N gives pop at N+1, push at N+2, and IDLE again at N+3; maximum throughput is one packet per 3 cycles.
REQ-017 A destination ID >= drvrs that is not broadcast SHALL cause no push in PUSH and increment drop_cnt by 1.
REQ-018 A destination equal to the source SHALL be delivered normally (loopback).
REQ-019 A pndng change after the IDLE decision SHALL NOT alter the current transaction.
REQ-020 Pop and push SHALL never both be asserted in the same cycle; at most one pop bit SHALL be high.
REQ-021 With all devices pending continuously, each device SHALL be served once per drvrs transactions (no starvation).

Reset
REQ-022 When reset=1 at a clock edge: state=IDLE, pop=0, push=0, D_push=0, busy=0, drop_cnt=0, last_grant=drvrs-1 (device 0 has first priority).
REQ-023 Reset asserted in POP or PUSH SHALL abort the transaction; a packet already popped is lost and is not counted in drop_cnt.

Configuration
REQ-024 Macro BUS_ARB_BCAST_EN defined: destination ID 8'hFF SHALL assert push on every device except the source in the same PUSH cycle.
REQ-025 Macro BUS_ARB_BCAST_EN undefined: 8'hFF SHALL be treated as an invalid destination (dropped, drop_cnt+1).

Structure
REQ-026 Package bus_arb_pkg SHALL hold the FSM state enum (IDLE, POP, PUSH), DEST_W=8, and BCAST_ID=8'hFF.
REQ-027 Round-robin selection SHALL be a sub-module rr_arbiter (inputs req, last_grant; outputs gnt_idx, gnt_valid; combinational).

Verification
REQ-028 Reset, then pndng=4'b0001 with D_pop[0]=16'h02AB -> pop[0] at N+1, push[2] with D_push=16'h02AB at N+2, busy low at N+3.
REQ-029 pndng=4'b1111 held for 8 transactions -> grant order 0,1,2,3,0,1,2,3.
REQ-030 Packet 16'h07CD from device 1 with drvrs=4 -> no push, drop_cnt=1.
REQ-031 BUS_ARB_BCAST_EN defined, packet 16'hFF11 from device 2 -> push=4'b1011 in one cycle; macro undefined -> push=0 and drop_cnt=1.
REQ-032 Reset asserted during PUSH -> push deasserted on the next edge, state IDLE, drop_cnt=0, next grant goes to device 0.
